// File: rtl/jtpang_pal_pkg.sv
// Shared constants and types for the palette arbiter.
// Slot numbers, RAM geometry and CPU sequencer states.
package jtpang_pal_pkg;

  localparam int AW = 12;
  localparam int SWEEP_LEN = 1 << AW;

  localparam logic [2:0] PH_HI  = 3'd0;
  localparam logic [2:0] PH_CPU = 3'd1;
  localparam logic [2:0] PH_GB  = 3'd2;
  localparam logic [2:0] PH_MAX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD1,
    ST_RD2,
    ST_ACK
  } cpu_st_t;

  function automatic logic [AW-1:0] cpu_map(
    input logic [10:0] a,
    input logic        bank
  );
    return {a[0], bank, a[10:1]};
  endfunction

endpackage

// File: rtl/jtpang_pal_arb.sv
// Palette RAM arbiter: video colour fetch,
// CPU access slots and post-reset clear sweep.
module jtpang_pal_arb
  import jtpang_pal_pkg::*;
#(
  parameter logic CLR_EN = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [10:0]   vid_idx,
  input  logic          cpu_cs,
  input  logic          cpu_wr_n,
  input  logic [10:0]   cpu_addr,
  input  logic          pal_bank,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_ok,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_q,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          busy
);

  logic [2:0]  ph;
  logic [10:0] idx;
  logic [3:0]  nr;
  logic [3:0]  ng;
  logic [3:0]  nb;
  logic [AW:0] clr_cnt;
  cpu_st_t     st;
  cpu_st_t     st_nx;
  logic        grant;
  logic        active;
  logic        vid_on;
  logic        cpu_slot;

  assign active = LHBL & LVBL;
  assign vid_on = active & ~busy;

  // CPU sequencer: slot grant and next state
  always_comb begin
    grant    = 1'b0;
    st_nx    = st;
    cpu_slot = ~busy &
      (~active | (~pxl_cen & (ph == PH_CPU)));
    unique case (st)
      ST_IDLE: begin
        if (cpu_cs && cpu_slot) begin
          grant = 1'b1;
          st_nx = cpu_wr_n ? ST_RD1 : ST_WR;
        end
      end
      ST_WR:   st_nx = ST_ACK;
      ST_RD1:  st_nx = ST_RD2;
      ST_RD2:  st_nx = ST_ACK;
      ST_ACK:  if (!cpu_cs) st_nx = ST_IDLE;
      default: st_nx = ST_IDLE;
    endcase
  end

  // CPU sequencer state register
  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nx;
  end

  // Slot counter, restarted by every pixel enable
  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= PH_MAX;
    end else if (pxl_cen) begin
      ph <= 3'd0;
    end else if (ph != PH_MAX) begin
      ph <= ph + 3'd1;
    end
  end

  // Colour fetch pipeline and pixel output
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      nr    <= '0;
      ng    <= '0;
      nb    <= '0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      if (pxl_cen) idx <= vid_idx;
      if (!vid_on) begin
        {red, green, blue} <= '0;
      end else if (pxl_cen) begin
        {red, green, blue} <= {nr, ng, nb};
      end
      if (vid_on && !pxl_cen && ph == PH_CPU)
        nr <= ram_q[3:0];
      if (vid_on && !pxl_cen && ph == PH_GB)
        {ng, nb} <= ram_q;
    end
  end

  // RAM port: clear sweep, CPU slot, video reads
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
      busy     <= CLR_EN;
      clr_cnt  <= '0;
    end else begin
      ram_we <= 1'b0;
      if (busy) begin
        if (clr_cnt[AW]) begin
          busy <= 1'b0;
        end else begin
          ram_addr <= clr_cnt[AW-1:0];
          ram_we   <= 1'b1;
          ram_din  <= '0;
          clr_cnt  <= clr_cnt + 1'b1;
        end
      end else if (grant) begin
        ram_addr <= cpu_map(cpu_addr, pal_bank);
        ram_we   <= ~cpu_wr_n;
        if (!cpu_wr_n) ram_din <= cpu_dout;
      end else if (vid_on && pxl_cen) begin
        ram_addr <= {1'b0, vid_idx};
      end else if (vid_on && ph == PH_HI) begin
        ram_addr <= {1'b1, idx};
      end
    end
  end

  // CPU read data and completion flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ok  <= 1'b0;
      cpu_din <= '0;
    end else begin
      cpu_ok <= (st_nx == ST_ACK);
      if (st == ST_RD2) cpu_din <= ram_q;
    end
  end

endmodule

// File: tb/tb_jtpang_pal_arb.sv
// Self-checking bench for jtpang_pal_arb.
// Bench RAM, tables, random CPU and pixel traffic.
module tb_jtpang_pal_arb;

  logic        rst;
  logic        clk;
  logic        pxl_cen;
  logic        LHBL;
  logic        LVBL;
  logic [10:0] vid_idx;
  logic        cpu_cs;
  logic        cpu_wr_n;
  logic [10:0] cpu_addr;
  logic        pal_bank;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_ok;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_q;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        busy;

  jtpang_pal_arb #(.CLR_EN(1'b1)) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen),
    .LHBL(LHBL), .LVBL(LVBL), .vid_idx(vid_idx),
    .cpu_cs(cpu_cs), .cpu_wr_n(cpu_wr_n),
    .cpu_addr(cpu_addr), .pal_bank(pal_bank),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_ok(cpu_ok), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_din(ram_din),
    .ram_q(ram_q), .red(red), .green(green),
    .blue(blue), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  logic [7:0] exp_mem [0:4095];
  int n_tests;
  int n_fail;
  int cyc;
  int last_p;
  int pcnt;
  bit pix_run;
  int we_cnt;
  int we_addr;
  int we_data;
  int we_rel;

  typedef struct {
    bit          wr;
    logic [10:0] a;
    logic        bank;
    logic [7:0]  d;
    logic [11:0] ram_a;
    logic [7:0]  q;
    int          lat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic int bmap(input logic [10:0] a,
                              input logic b);
    int ai;
    ai = int'(a);
    return (ai % 2) * 2048 + int'(b) * 1024 + ai / 2;
  endfunction

  task tick();
    @(posedge clk);
    cyc++;
    if (pxl_cen) last_p = cyc;
    #1;
    if (ram_we) begin
      we_cnt++;
      we_addr = int'(ram_addr);
      we_data = int'(ram_din);
      we_rel  = cyc - last_p;
    end
    if (pix_run) begin
      pcnt    = (pcnt + 1) % 4;
      pxl_cen = (pcnt == 0);
    end else begin
      pxl_cen = 1'b0;
    end
  endtask

  task preload(input int a, input logic [7:0] d);
    pre_addr = 12'(a);
    pre_data = d;
    pre_we   = 1'b1;
    exp_mem[a] = d;
    tick();
    pre_we = 1'b0;
  endtask

  task cpu_acc(input bit wr, input logic [10:0] a,
               input logic bank, input logic [7:0] d,
               output logic [7:0] rd, output int lat,
               output bit ok, output int okrel);
    cpu_cs   = 1'b1;
    cpu_wr_n = ~wr;
    cpu_addr = a;
    pal_bank = bank;
    cpu_dout = d;
    lat = 0;
    ok  = 1'b0;
    okrel = -1;
    while (lat < 20 && !ok) begin
      tick();
      lat++;
      if (cpu_ok) begin
        ok = 1'b1;
        okrel = cyc - last_p;
      end
    end
    rd = cpu_din;
    cpu_cs   = 1'b0;
    cpu_wr_n = 1'b1;
    tick();
  endtask

  task sweep(input int abort_at, output int n,
             output int seq_err, output int side_err,
             output bit done);
    bit stop;
    n = 0;
    seq_err = 0;
    side_err = 0;
    done = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 5000 && !done && !stop; i++) begin
      tick();
      if ({red, green, blue} != 12'd0 || cpu_ok)
        side_err++;
      if (busy && ram_we) begin
        if (ram_addr != 12'(n) || ram_din != 8'd0)
          seq_err++;
        if (n == abort_at) stop = 1'b1;
        n++;
      end else if (!busy) begin
        done = 1'b1;
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    int lat;
    int okrel;
    bit ok;
    bit done;
    int n;
    int serr;
    int xerr;
    int w0;
    int mx;
    int va;
    bit wr;
    logic [10:0] a;
    logic b;
    logic [7:0] d;
    logic [7:0] dr;
    logic [7:0] dg;

    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    last_p = 0;
    pcnt = 0;
    pix_run = 1'b0;
    we_cnt = 0;
    we_addr = 0;
    we_data = 0;
    we_rel = 0;
    rst = 1'b1;
    pxl_cen = 1'b0;
    LHBL = 1'b1;
    LVBL = 1'b0;
    vid_idx = 11'h123;
    cpu_cs = 1'b0;
    cpu_wr_n = 1'b1;
    cpu_addr = '0;
    pal_bank = 1'b0;
    cpu_dout = '0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    for (int i = 0; i < 4096; i++) exp_mem[i] = 8'd0;

    tbl[0] = '{1'b1, 11'h003, 1'b1, 8'h5A, 12'hC01, 8'h00, 2};
    tbl[1] = '{1'b0, 11'h003, 1'b1, 8'h00, 12'hC01, 8'h5A, 3};
    tbl[2] = '{1'b1, 11'h004, 1'b1, 8'h77, 12'h402, 8'h00, 2};
    tbl[3] = '{1'b0, 11'h004, 1'b1, 8'h00, 12'h402, 8'h77, 3};
    tbl[4] = '{1'b1, 11'h7FF, 1'b0, 8'hE1, 12'hBFF, 8'h00, 2};
    tbl[5] = '{1'b0, 11'h7FF, 1'b0, 8'h00, 12'hBFF, 8'hE1, 3};
    tbl[6] = '{1'b1, 11'h000, 1'b0, 8'h3C, 12'h000, 8'h00, 2};
    tbl[7] = '{1'b0, 11'h000, 1'b1, 8'h00, 12'h400, 8'h00, 3};
    tbl[8] = '{1'b0, 11'h000, 1'b0, 8'h00, 12'h000, 8'h3C, 3};

    repeat (3) tick();
    chk("rst_busy", 32'(busy), 1);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_din", 32'(ram_din), 0);
    chk("rst_cpu", {cpu_ok, cpu_din}, 0);
    chk("rst_rgb", {red, green, blue}, 0);

    cpu_cs = 1'b1;
    cpu_addr = 11'h004;
    pal_bank = 1'b1;
    LVBL = 1'b1;
    pix_run = 1'b1;
    rst = 1'b0;
    sweep(-1, n, serr, xerr, done);
    chk("sweep_done", 32'(done), 1);
    chk("sweep_len", n, 4096);
    chk("sweep_seq", serr, 0);
    chk("sweep_quiet", xerr, 0);
    chk("sweep_last", we_addr, 4095);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (cpu_ok) ok = 1'b1;
    end
    chk("post_sweep_ok", 32'(ok), 1);
    chk("post_sweep_din", 32'(cpu_din), 0);
    cpu_cs = 1'b0;
    repeat (2) tick();

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    sweep(2000, n, serr, xerr, done);
    chk("abort_at", n, 2001);
    rst = 1'b1;
    repeat (2) tick();
    chk("abort_busy", 32'(busy), 1);
    chk("abort_idle", {ram_we, ram_addr}, 0);
    rst = 1'b0;
    sweep(-1, n, serr, xerr, done);
    chk("resweep_len", n, 4096);
    chk("resweep_seq", serr, 0);
    chk("resweep_done", 32'(done), 1);

    LVBL = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 9; i++) begin
      w0 = we_cnt;
      cpu_acc(tbl[i].wr, tbl[i].a, tbl[i].bank,
              tbl[i].d, rd, lat, ok, okrel);
      chk($sformatf("tbl%0d_ok", i), 32'(ok), 1);
      chk($sformatf("tbl%0d_lat", i),
          32'(lat <= tbl[i].lat), 1);
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d_we", i), we_cnt - w0, 1);
        chk($sformatf("tbl%0d_wa", i), we_addr,
            int'(tbl[i].ram_a));
        chk($sformatf("tbl%0d_wd", i), we_data,
            int'(tbl[i].d));
        exp_mem[tbl[i].ram_a] = tbl[i].d;
      end else begin
        chk($sformatf("tbl%0d_q", i), 32'(rd),
            32'(tbl[i].q));
        chk($sformatf("tbl%0d_nowe", i), we_cnt - w0, 0);
      end
    end

    preload(12'h005, 8'h0A);
    preload(12'h805, 8'hBC);
    vid_idx = 11'h005;
    LVBL = 1'b1;
    repeat (12) tick();
    chk("pix_red", 32'(red), 32'hA);
    chk("pix_green", 32'(green), 32'hB);
    chk("pix_blue", 32'(blue), 32'hC);
    LHBL = 1'b0;
    repeat (2) tick();
    chk("hblank_rgb", {red, green, blue}, 0);
    LHBL = 1'b1;
    repeat (8) tick();

    w0 = we_cnt;
    cpu_acc(1'b1, 11'h003, 1'b1, 8'h5A, rd, lat, ok,
            okrel);
    chk("act_wr_ok", 32'(ok), 1);
    chk("act_wr_cnt", we_cnt - w0, 1);
    chk("act_wr_addr", we_addr, 12'hC01);
    chk("act_wr_slot", we_rel, 2);
    chk("act_ok_slot", okrel, 3);
    exp_mem[12'hC01] = 8'h5A;

    for (int i = 0; i < 8 && !pxl_cen; i++) tick();
    w0 = we_cnt;
    cpu_cs = 1'b1;
    cpu_wr_n = 1'b0;
    cpu_addr = 11'h011;
    cpu_dout = 8'hFF;
    tick();
    cpu_cs = 1'b0;
    cpu_wr_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ok) ok = 1'b1;
    end
    chk("glitch_nowe", we_cnt - w0, 0);
    chk("glitch_nook", 32'(ok), 0);

    for (int i = 0; i < 150; i++) begin
      LVBL = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a = 11'($urandom_range(0, 2047));
      b = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      mx = LVBL ? 9 : (wr ? 2 : 3);
      w0 = we_cnt;
      cpu_acc(wr, a, b, d, rd, lat, ok, okrel);
      chk("rnd_ok", 32'(ok), 1);
      chk("rnd_lat", 32'(lat <= mx), 1);
      if (wr) begin
        chk("rnd_wa", we_addr, bmap(a, b));
        exp_mem[bmap(a, b)] = d;
      end else begin
        chk("rnd_q", 32'(rd), 32'(exp_mem[bmap(a, b)]));
        chk("rnd_nowe", we_cnt - w0, 0);
      end
    end

    for (int i = 0; i < 16; i++) begin
      LVBL = 1'b0;
      va = $urandom_range(0, 2047);
      dr = 8'($urandom_range(0, 255));
      dg = 8'($urandom_range(0, 255));
      cpu_acc(1'b1, 11'((va % 1024) * 2),
              1'((va / 1024) % 2), dr, rd, lat, ok, okrel);
      exp_mem[va] = dr;
      cpu_acc(1'b1, 11'((va % 1024) * 2 + 1),
              1'((va / 1024) % 2), dg, rd, lat, ok, okrel);
      exp_mem[va + 2048] = dg;
      vid_idx = 11'(va);
      LVBL = 1'b1;
      repeat (12) tick();
      chk("rnd_pix", {red, green, blue},
          {20'd0, exp_mem[va][3:0], exp_mem[va + 2048]});
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
